code_loader: RTL



---
 rtl/code_loader_pkg.sv | 38 +++
 rtl/code_loader_if.sv | 35 +++
 rtl/code_loader_packer.sv | 47 ++++
 rtl/code_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
// Shared types for the program loader: FSM states, write beat, lane-mask helper.
// No logic of its own; imported by the loader, its packer and the bus interface.
// Latency/backpressure: not applicable.
package code_loader_pkg;

  localparam int LOADER_WORD_BYTES = 4;
  localparam int LOADER_CNT_W      = 16;

  localparam logic [63:0] BEGINNING_TEXT = 64'h0000_0000_0000_0000;
  localparam logic [63:0] END_TEXT       = 64'h0000_0000_0000_0FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_VERIFY_RD,
    ST_VERIFY_CMP,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef struct packed {
    logic [63:0]                  addr;
    logic [31:0]                  data;
    logic [LOADER_WORD_BYTES-1:0] be;
  } wr_beat_t;

  function automatic logic [LOADER_WORD_BYTES-1:0] lanes_to_mask(input logic [2:0] lanes);
    case (lanes)
      3'd0:    lanes_to_mask = 4'b0000;
      3'd1:    lanes_to_mask = 4'b0001;
      3'd2:    lanes_to_mask = 4'b0011;
      3'd3:    lanes_to_mask = 4'b0111;
      default: lanes_to_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/code_loader_if.sv
// Byte stream, instruction-memory port and status bundle of the program loader.
// master = loader side, slave = host/memory/control side.
// Latency/backpressure: byte stream is valid/ready; memory port is strobe-only.
interface code_loader_if;
  import code_loader_pkg::*;

  logic                    iStart;
  logic                    iByteValid;
  logic [7:0]              iByteData;
  logic                    oByteReady;
  logic                    iEnd;
  logic                    oWriteEnable;
  logic                    oReadEnable;
  logic [7:0]              oByteEnable;
  logic [63:0]             oAddress;
  logic [63:0]             oWriteData;
  logic [31:0]             iReadData;
  logic                    oBusy;
  logic                    oDone;
  logic                    oError;
  logic [LOADER_CNT_W-1:0] oWordCount;

  modport master (
    input  iStart, iByteValid, iByteData, iEnd, iReadData,
    output oByteReady, oWriteEnable, oReadEnable, oByteEnable, oAddress,
           oWriteData, oBusy, oDone, oError, oWordCount
  );

  modport slave (
    output iStart, iByteValid, iByteData, iEnd, iReadData,
    input  oByteReady, oWriteEnable, oReadEnable, oByteEnable, oAddress,
           oWriteData, oBusy, oDone, oError, oWordCount
  );

endinterface

// File: rtl/code_loader_packer.sv
// Little-endian byte-to-word packer: lane index, packing register, enable mask.
// word_nxt/mask_nxt are combinational and already include the byte accepted this cycle.
// Latency/backpressure: none; the FSM gates accept.
module code_loader_packer
  import code_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         accept,
  input  logic                         flush,
  input  logic [7:0]                   byte_dat,
  output logic [1:0]                   idx,
  output logic [31:0]                  word_nxt,
  output logic [LOADER_WORD_BYTES-1:0] mask_nxt
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;

  always_comb begin
    word_nxt = word_q;
    if (accept) begin
      word_nxt[{idx_q, 3'b000} +: 8] = byte_dat;
    end
    mask_nxt = lanes_to_mask({1'b0, idx_q} + {2'b00, accept});
  end

  // The register is zeroed after every word so unreceived lanes of a flushed word read as 0.
  always_ff @(posedge clk) begin
    if (rst || clear || flush) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      if (idx_q == 2'd3) begin
        word_q <= '0;
        idx_q  <= '0;
      end else begin
        word_q <= word_nxt;
        idx_q  <= idx_q + 2'd1;
      end
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/code_loader.sv
// Program loader: packs a byte stream into 32-bit words, one write strobe per word; CODE_LOADER_VERIFY_EN adds read-back check.
// Latency: write strobe in the cycle after the last byte of a word; 5 cycles/word sustained (+RD_LATENCY+1 with verify).
// Backpressure: oByteReady is low outside COLLECT, so bytes stall during write/verify and after DONE/ERROR.
module code_loader
  import code_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = BEGINNING_TEXT,
  parameter logic [63:0] LIMIT_ADDR = END_TEXT,
  parameter int unsigned RD_LATENCY = 2
)
(
  input logic          iCLK,
  input logic          iRST,
  code_loader_if.master bus
);

  loader_state_t           state;
  wr_beat_t                wr_q;
  logic [63:0]             ptr;
  logic [LOADER_CNT_W-1:0] cnt_q;
  logic                    rdy_q;
  logic                    we_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic                    flushed_q;

  logic [1:0]                   idx;
  logic [31:0]                  word_nxt;
  logic [LOADER_WORD_BYTES-1:0] mask_nxt;
  logic [64:0]                  ptr_end;
  logic                         byte_acc;
  logic                         overflow;
  logic                         start;
  logic                         pack_accept;
  logic                         pack_flush;

  assign byte_acc    = rdy_q && bus.iByteValid;
  // 65-bit compare so a region ending near the top of the address space cannot wrap.
  assign ptr_end     = {1'b0, ptr} + 65'd3;
  assign overflow    = ptr_end > {1'b0, LIMIT_ADDR};
  assign start       = bus.iStart && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign pack_accept = byte_acc && !overflow;
  assign pack_flush  = rdy_q && bus.iEnd && !(byte_acc && overflow);

  code_loader_packer u_packer (
    .clk      (iCLK),
    .rst      (iRST),
    .clear    (start),
    .accept   (pack_accept),
    .flush    (pack_flush),
    .byte_dat (bus.iByteData),
    .idx      (idx),
    .word_nxt (word_nxt),
    .mask_nxt (mask_nxt)
  );

`ifdef CODE_LOADER_VERIFY_EN
  localparam logic [7:0] RD_CNT_INIT = 8'(RD_LATENCY - 1);
  logic        re_q;
  logic [7:0]  rd_cnt;
  logic [31:0] lane_bits;
  assign lane_bits = {{8{wr_q.be[3]}}, {8{wr_q.be[2]}}, {8{wr_q.be[1]}}, {8{wr_q.be[0]}}};
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= ST_IDLE;
      wr_q      <= '0;
      ptr       <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      flushed_q <= 1'b0;
`ifdef CODE_LOADER_VERIFY_EN
      re_q      <= 1'b0;
      rd_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (bus.iStart) begin
            state     <= ST_COLLECT;
            ptr       <= BASE_ADDR;
            wr_q      <= '{addr: BASE_ADDR, data: 32'h0, be: 4'h0};
            cnt_q     <= '0;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (byte_acc && overflow) begin
            state  <= ST_ERROR;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else if ((byte_acc && (idx == 2'd3 || bus.iEnd)) || (bus.iEnd && idx != 2'd0)) begin
            state     <= ST_WRITE;
            rdy_q     <= 1'b0;
            we_q      <= 1'b1;
            wr_q.data <= word_nxt;
            wr_q.be   <= mask_nxt;
            flushed_q <= bus.iEnd;
          end else if (bus.iEnd) begin
            state  <= ST_DONE;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          we_q  <= 1'b0;
          cnt_q <= cnt_q + LOADER_CNT_W'(1);
          ptr   <= ptr + 64'd4;
`ifdef CODE_LOADER_VERIFY_EN
          // Address stays on the written word until the compare is done.
          state  <= ST_VERIFY_RD;
          re_q   <= 1'b1;
          rd_cnt <= RD_CNT_INIT;
`else
          wr_q.addr <= ptr + 64'd4;
          if (flushed_q) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ST_COLLECT;
            rdy_q <= 1'b1;
          end
`endif
        end
`ifdef CODE_LOADER_VERIFY_EN
        ST_VERIFY_RD: begin
          if (rd_cnt == 8'd0) begin
            re_q  <= 1'b0;
            state <= ST_VERIFY_CMP;
          end else begin
            rd_cnt <= rd_cnt - 8'd1;
          end
        end
        ST_VERIFY_CMP: begin
          wr_q.addr <= ptr;
          if (((bus.iReadData ^ wr_q.data) & lane_bits) != 32'h0) begin
            state  <= ST_ERROR;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else if (flushed_q) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ST_COLLECT;
            rdy_q <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oByteReady   = rdy_q;
  assign bus.oWriteEnable = we_q;
  assign bus.oByteEnable  = {4'b0000, wr_q.be};
  assign bus.oAddress     = wr_q.addr;
  assign bus.oWriteData   = {32'h0, wr_q.data};
  assign bus.oBusy        = busy_q;
  assign bus.oDone        = done_q;
  assign bus.oError       = err_q;
  assign bus.oWordCount   = cnt_q;

`ifdef CODE_LOADER_VERIFY_EN
  assign bus.oReadEnable  = re_q;
`else
  logic unused_verify;
  assign bus.oReadEnable  = 1'b0;
  assign unused_verify    = ^{bus.iReadData, RD_LATENCY[0]};
`endif

endmodule
